// File: rtl/udp_tx_sched_if.sv
// Bundle of requester, header-generator and payload-stream signals around udp_tx_sched.
// The master modport is the scheduler; the slave modport is the requester/generator side.
interface udp_tx_sched_if #(
  parameter int N    = 2,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_src_port;
  logic [16*NREQ-1:0] req_dst_port;
  logic [16*NREQ-1:0] req_len;
  logic [16*NREQ-1:0] req_cksum;
  logic [NREQ-1:0]    grant;
  logic               hdr_go;
  logic [15:0]        hdr_src_port;
  logic [15:0]        hdr_dst_port;
  logic [15:0]        hdr_len;
  logic [15:0]        hdr_cksum;
  logic               hdr_last;
  logic [NREQ-1:0]    pay_valid;
  logic [N*NREQ-1:0]  pay_data;
  logic [NREQ-1:0]    pay_ready;
  logic               pay_axiov;
  logic [N-1:0]       pay_axiod;
  logic               pay_axi_last;
  logic               done;
  logic               err;

  modport master (
    input  req_valid, req_src_port, req_dst_port, req_len, req_cksum,
    input  hdr_last, pay_valid, pay_data,
    output grant, hdr_go, hdr_src_port, hdr_dst_port, hdr_len, hdr_cksum,
    output pay_ready, pay_axiov, pay_axiod, pay_axi_last, done, err
  );

  modport slave (
    output req_valid, req_src_port, req_dst_port, req_len, req_cksum,
    output hdr_last, pay_valid, pay_data,
    input  grant, hdr_go, hdr_src_port, hdr_dst_port, hdr_len, hdr_cksum,
    input  pay_ready, pay_axiov, pay_axiod, pay_axi_last, done, err
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP header generator among NREQ requesters,
// then forwarding the winner's payload as an N-bit valid/data/last stream.
module udp_tx_sched #(
  parameter int N    = 2,
  parameter int NREQ = 2
) (
  input  logic           clk,
  input  logic           rst,
  udp_tx_sched_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SH = $clog2(N);

  typedef enum logic [2:0] {IDLE, HDR, PAY, GAP, REJECT} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [18:0]     cnt;
  logic [NREQ-1:0] grant_r;
  logic            go_r;
  logic [15:0]     src_r, dst_r, len_r, ck_r;
  logic            axiov_r;
  logic [N-1:0]    axiod_r;
  logic            alast_r;
  logic            done_r;
  logic            err_r;

  logic            found;
  logic [IW-1:0]   hit;
  logic [15:0]     sel_src, sel_dst, sel_len, sel_ck;
  logic            sel_pv;
  logic [N-1:0]    sel_pd;
  logic [18:0]     len_beats;
  logic [IW-1:0]   next_ptr;

  // Rotating priority scan: descending j so the lowest offset from ptr is the last write.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && (i == (int'(ptr) + j) % NREQ)) begin
          found = 1'b1;
          hit   = IW'(i);
        end
      end
    end

    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    sel_ck  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hit == IW'(i)) begin
        sel_src = bus.req_src_port[16*i +: 16];
        sel_dst = bus.req_dst_port[16*i +: 16];
        sel_len = bus.req_len[16*i +: 16];
        sel_ck  = bus.req_cksum[16*i +: 16];
      end
    end

    sel_pv = 1'b0;
    sel_pd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_pv = bus.pay_valid[i];
        sel_pd = bus.pay_data[N*i +: N];
      end
    end
  end

  // Bytes to N-bit beats: the 3 extra bits keep len*8 exact in 19 bits.
  assign len_beats = {sel_len, 3'b000} >> SH;
  assign next_ptr  = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      grant_r <= '0;
      go_r    <= 1'b0;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      ck_r    <= '0;
      axiov_r <= 1'b0;
      axiod_r <= '0;
      alast_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      axiov_r <= 1'b0;
      alast_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            win   <= hit;
            src_r <= sel_src;
            dst_r <= sel_dst;
            len_r <= sel_len;
            ck_r  <= sel_ck;
            cnt   <= len_beats;
            if (sel_len > 16'hFFF7) begin
              err_r <= 1'b1;
              state <= REJECT;
            end else begin
              grant_r <= NREQ'(1) << hit;
              go_r    <= 1'b1;
              state   <= HDR;
            end
          end
        end
        HDR: begin
          if (bus.hdr_last) begin
            if (cnt != '0) begin
              state <= PAY;
            end else begin
              go_r    <= 1'b0;
              grant_r <= '0;
              done_r  <= 1'b1;
              state   <= GAP;
            end
          end
        end
        PAY: begin
          if (sel_pv) begin
            axiov_r <= 1'b1;
            axiod_r <= sel_pd;
            cnt     <= cnt - 19'd1;
            if (cnt == 19'd1) begin
              alast_r <= 1'b1;
              go_r    <= 1'b0;
              grant_r <= '0;
              done_r  <= 1'b1;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          ptr   <= next_ptr;
          state <= IDLE;
        end
        REJECT: begin
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pay_ready    = (state == PAY) ? grant_r : '0;
  assign bus.grant        = grant_r;
  assign bus.hdr_go       = go_r;
  assign bus.hdr_src_port = src_r;
  assign bus.hdr_dst_port = dst_r;
  assign bus.hdr_len      = len_r;
  assign bus.hdr_cksum    = ck_r;
  assign bus.pay_axiov    = axiov_r;
  assign bus.pay_axiod    = axiod_r;
  assign bus.pay_axi_last = alast_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: directed scenarios followed by randomized datagrams, all
// checked against a datagram-level model (RR pointer, byte-to-beat expansion).
module tb_udp_tx_sched;
  localparam int N    = 2;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_tx_sched_if #(.N(N), .NREQ(NREQ)) bus ();
  udp_tx_sched #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;

  int              rr;
  logic [NREQ-1:0] rv;
  logic [15:0]     f_src[NREQ], f_dst[NREQ], f_len[NREQ], f_ck[NREQ];
  bit              pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic apply();
    bus.req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_src_port[16*i +: 16] = f_src[i];
      bus.req_dst_port[16*i +: 16] = f_dst[i];
      bus.req_len[16*i +: 16]      = f_len[i];
      bus.req_cksum[16*i +: 16]    = f_ck[i];
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] c);
    f_src[i] = s; f_dst[i] = d; f_len[i] = l; f_ck[i] = c; rv[i] = 1'b1;
    apply();
  endtask

  task automatic drive_pay(input int k, input bit v, input logic [N-1:0] d);
    for (int i = 0; i < NREQ; i++) begin
      if (i == k) begin
        bus.pay_valid[i]       = v;
        bus.pay_data[N*i +: N] = v ? d : N'($urandom);
      end else begin
        bus.pay_valid[i]       = 1'($urandom);
        bus.pay_data[N*i +: N] = N'($urandom);
      end
    end
  endtask

  // Model winner: first valid requester at or after the RR pointer.
  function automatic int pick();
    for (int j = 0; j < NREQ; j++) begin
      if (rv[(rr + j) % NREQ]) return (rr + j) % NREQ;
    end
    return -1;
  endfunction

  // One datagram. mode: 0 always-valid, 1 fixed toggle pattern, 2 random.
  // drop: 0 keep requests, 1 drop winner, 2 drop all. abort_at>=0 asserts reset after that many beats.
  task automatic xfer(input int dly, input int mode, input int drop, input int abort_at);
    int k, c0, nbeats, got, nlast, last_at, ndone, acc, pi, first_cyc;
    bit seen, oversize, holdbad, readybad, drv, rdy;
    logic [NREQ-1:0] oh;
    logic [N-1:0] exp_q[$], src_q[$], tmp;
    logic [7:0] by;

    k = pick();
    if (k < 0) return;
    oh = NREQ'(1) << k;
    oversize = (f_len[k] > 16'hFFF7);
    seen = 0; c0 = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (bus.grant !== '0 || bus.err === 1'b1) begin seen = 1; c0 = c; end
    end
    chk("start_seen", 32'(seen), 1);
    if (!seen) return;
    chk("start_latency", c0, 0);

    if (oversize) begin
      chk("rej_err", bus.err, 1);
      chk("rej_grant", bus.grant, 0);
      chk("rej_go", bus.hdr_go, 0);
      if (drop == 1) rv[k] = 1'b0;
      if (drop == 2) rv = '0;
      apply();
      @(negedge clk);
      chk("rej_err_pulse", bus.err, 0);
      chk("rej_go_after", bus.hdr_go, 0);
      rr = (k + 1) % NREQ;
      return;
    end

    chk("grant_onehot", bus.grant, oh);
    chk("go_at_grant", bus.hdr_go, 1);
    chk("hdr_src", bus.hdr_src_port, f_src[k]);
    chk("hdr_dst", bus.hdr_dst_port, f_dst[k]);
    chk("hdr_len", bus.hdr_len, f_len[k]);
    chk("hdr_cksum", bus.hdr_cksum, f_ck[k]);

    nbeats = int'(f_len[k]) * 8 / N;
    for (int b = 0; b < int'(f_len[k]); b++) begin
      by = 8'($urandom);
      for (int s = 0; s < 8 / N; s++) begin
        tmp = N'(by >> (8 - N * (s + 1)));
        src_q.push_back(tmp);
        exp_q.push_back(tmp);
      end
    end

    holdbad = 0; readybad = 0;
    for (int d = 0; d < dly; d++) begin
      if (bus.hdr_go !== 1'b1) holdbad = 1;
      @(negedge clk);
    end
    bus.hdr_last = 1'b1;
    drv = (mode == 0) && (src_q.size() > 0);
    rdy = 0;
    drive_pay(k, drv, (src_q.size() > 0) ? src_q[0] : '0);

    got = 0; nlast = 0; last_at = 0; ndone = 0; acc = 0; pi = 0; first_cyc = -1;
    for (int c = 0; c < 600 && ndone == 0; c++) begin
      @(negedge clk);
      bus.hdr_last = 1'b0;
      if (drv && rdy) begin tmp = src_q.pop_front(); acc++; end
      if (bus.pay_axiov === 1'b1) begin
        got++;
        if (first_cyc < 0) first_cyc = c;
        if (exp_q.size() > 0) chk("beat_data", bus.pay_axiod, exp_q.pop_front());
        if (bus.pay_axi_last === 1'b1) last_at = got;
      end
      if (bus.pay_axi_last === 1'b1) nlast++;
      if ((bus.pay_ready & ~oh) !== '0) readybad = 1;
      if (bus.done === 1'b1) begin
        ndone++;
      end else begin
        if (bus.hdr_go !== 1'b1) holdbad = 1;
        if (abort_at >= 0 && acc == abort_at) begin
          rst = 1'b0;
          bus.pay_valid = '0;
          return;
        end
        rdy = bus.pay_ready[k];
        if (src_q.size() == 0) drv = 0;
        else if (mode == 0) drv = 1;
        else if (mode == 1) begin drv = pat[pi % 7]; pi++; end
        else drv = 1'($urandom);
        drive_pay(k, drv, (src_q.size() > 0) ? src_q[0] : '0);
      end
    end

    chk("done_seen", ndone, 1);
    chk("beat_count", got, nbeats);
    chk("last_count", nlast, 32'(nbeats > 0));
    chk("last_position", last_at, nbeats);
    chk("hdr_go_hold", 32'(holdbad), 0);
    chk("ready_isolation", 32'(readybad), 0);
    if (mode == 0 && nbeats > 0) chk("first_beat_latency", first_cyc, 1);
    chk("gap_grant", bus.grant, 0);
    chk("gap_go", bus.hdr_go, 0);
    chk("gap_ready", bus.pay_ready, 0);
    chk("gap_hdr_src_hold", bus.hdr_src_port, f_src[k]);
    chk("gap_hdr_len_hold", bus.hdr_len, f_len[k]);

    if (drop == 1) rv[k] = 1'b0;
    if (drop == 2) rv = '0;
    apply();
    bus.pay_valid = '0;
    @(negedge clk);
    chk("done_single_pulse", bus.done, 0);
    chk("idle_grant", bus.grant, 0);
    chk("idle_axiov", bus.pay_axiov, 0);
    rr = (k + 1) % NREQ;
  endtask

  initial begin
    rst = 1'b0;
    rr  = 0;
    rv  = '0;
    for (int i = 0; i < NREQ; i++) begin
      f_src[i] = '0; f_dst[i] = '0; f_len[i] = '0; f_ck[i] = '0;
    end
    apply();
    bus.hdr_last  = 1'b0;
    bus.pay_valid = '0;
    bus.pay_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_grant", bus.grant, 0);
    chk("rst_go", bus.hdr_go, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_axiov", bus.pay_axiov, 0);
    chk("rst_hdr_src", bus.hdr_src_port, 0);
    chk("rst_ready", bus.pay_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic datagram with header fields and 8 payload beats.
    set_req(0, 16'h1234, 16'h5678, 16'd2, 16'hABCD);
    xfer(3, 0, 1, -1);

    // Two continuous requesters alternate.
    set_req(0, 16'h0101, 16'h0202, 16'd1, 16'h0303);
    set_req(1, 16'h1111, 16'h2222, 16'd1, 16'h3333);
    xfer(1, 0, 0, -1);
    xfer(2, 0, 0, -1);
    xfer(0, 0, 0, -1);
    xfer(1, 0, 2, -1);

    // Zero-length payload goes straight to the gap.
    set_req(1, 16'h0AAA, 16'h0BBB, 16'd0, 16'h0CCC);
    xfer(2, 0, 1, -1);

    // Stalling source.
    set_req(1, 16'h4444, 16'h5555, 16'd1, 16'h6666);
    xfer(1, 1, 1, -1);

    // Oversize request rejected, next requester served.
    set_req(0, 16'h7777, 16'h8888, 16'hFFF8, 16'h9999);
    set_req(1, 16'hAAAA, 16'hBBBB, 16'd1, 16'hCCCC);
    xfer(0, 0, 1, -1);
    xfer(2, 0, 1, -1);

    // Reset in the middle of the payload.
    set_req(1, 16'hDEAD, 16'hBEEF, 16'd2, 16'hF00D);
    xfer(1, 0, 0, 3);
    @(negedge clk);
    chk("abort_grant", bus.grant, 0);
    chk("abort_go", bus.hdr_go, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_axiov", bus.pay_axiov, 0);
    chk("abort_axiod", bus.pay_axiod, 0);
    chk("abort_hdr_src", bus.hdr_src_port, 0);
    chk("abort_ready", bus.pay_ready, 0);
    rst = 1'b1;
    rr  = 0;
    set_req(0, 16'h1357, 16'h2468, 16'd1, 16'h0F0F);
    xfer(1, 0, 1, -1);
    xfer(1, 0, 1, -1);

    // Randomized datagrams.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && ($urandom_range(0, 2) != 0)) begin
          set_req(i, 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'($urandom_range(0, 5)),
                  16'($urandom));
        end
      end
      if (rv == '0) set_req(it % NREQ, 16'($urandom), 16'($urandom), 16'd3, 16'($urandom));
      xfer($urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 0 : 2, 1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Round-robin scheduler that shares one UDP header generator (N-bit header stream, start/hold input, last-beat output) among NREQ datagram requesters.
- Per datagram:
  - latches the winner's header fields and drives the generator's start/hold line;
  - waits for the header's last beat;
  - forwards the winner's payload as an N-bit stream with the same valid/data/last shape;
  - forces a one-cycle idle gap so the generator returns to its first field.
- Sits between the application payload sources and the IP/Ethernet framing stage.

Parameters:
- N, 2, bits per beat on header and payload streams; must divide 8.
- NREQ, 2, number of requesters; at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  NREQ  requester i has a datagram pending; fields held stable while high
- req_src_port  in  16*NREQ  per-requester source port (slice i = [16i+15:16i])
- req_dst_port  in  16*NREQ  per-requester destination port
- req_len  in  16*NREQ  payload length in bytes
- req_cksum  in  16*NREQ  payload ones-complement 16-bit sum
- grant  out  NREQ  one-hot winner; all zero when idle
- hdr_go  out  1  start/hold to header generator
- hdr_src_port, hdr_dst_port, hdr_len, hdr_cksum  out  16 each  registered fields of winner
- hdr_last  in  1  header generator last-beat flag
- pay_valid  in  NREQ  per-requester payload beat available
- pay_data  in  N*NREQ  per-requester payload beat, MSB-first
- pay_ready  out  NREQ  beat accepted this cycle (only winner's bit can be set)
- pay_axiov  out  1  payload beat valid
- pay_axiod  out  N  payload beat
- pay_axi_last  out  1  final payload beat
- done  out  1  one-cycle pulse, datagram finished
- err  out  1  one-cycle pulse, request rejected (oversize)

Behaviour:
- Reset (rst low at a clk edge) puts every output to 0, state to IDLE and the RR pointer to 0.
- Reset wins over all events; mid-datagram it aborts immediately with no done pulse.
- States and transitions:
  - IDLE: scan req_valid from the RR pointer upward, wrapping at NREQ.
    - First hit k: register k's fields into hdr_*; grant=onehot(k); load beat counter = req_len*8/N (19-bit).
    - If req_len > 16'hFFF7 → REJECT; else → HDR.
    - No hit: stay in IDLE.
  - HDR: hdr_go=1.
    - On hdr_last=1: → PAY if counter≠0, else → GAP.
  - PAY: hdr_go stays 1.
    - pay_ready[k]=1 combinationally.
    - When pay_valid[k]=1: register pay_data[k] onto pay_axiod, pay_axiov=1 next cycle, decrement counter.
    - The beat taking the counter to 0 carries pay_axi_last=1 → GAP.
    - pay_valid[k]=0 stalls: pay_axiov=0 that cycle; the counter holds.
  - GAP: one cycle, hdr_go=0, grant=0, done=1, RR pointer=k+1 mod NREQ → IDLE.
  - REJECT: one cycle, err=1, grant=0, hdr_go stays 0, RR pointer=k+1 mod NREQ → IDLE.
- Latency:
  - req_valid sampled high in IDLE at edge t → grant and hdr_go high after edge t.
  - First payload beat appears one cycle after hdr_last if pay_valid is already high.
- Requesters drop req_valid only after seeing done or err while granted.
- A request that goes low early is not cancelled; the transaction completes.
- Non-granted pay_valid is ignored; pay_ready for those bits stays 0.
- Hold times:
  - hdr_* fields stay stable from grant until GAP.
  - hdr_go never drops between HDR entry and GAP.
  - Minimum idle between datagrams is 1 cycle (GAP).
- Fairness: a requester that was just served has lowest priority next scan.
- Simultaneous requests resolve by RR order.
- Counter width: 16-bit length ×8/N fits 19 bits with no overflow.

Test Plan:
- N=2: req0 src=0x1234, dst=0x5678, len=2, cksum=0xABCD; hdr_last pulsed 3 cycles after grant → hdr_* match; hdr_go high through 8 payload beats; pay_axi_last on 8th beat; done pulses once; grant returns to 0.
- req0 and req1 both valid continuously, len=1 each → grants alternate 1,2,1,2 (one-hot); each pair of grants separated by exactly one GAP cycle with hdr_go=0.
- len=0 on req1 → after hdr_last go straight to GAP; no pay_axiov; done=1.
- len=1, pay_valid toggling 1,0,0,1,1,0,1 → exactly 4 output beats, data order preserved, pay_axi_last only on 4th.
- len=16'hFFF8 → err=1 for one cycle; hdr_go never rises; the next requester is served after.
- rst low mid-PAY (counter=5) → next cycle all outputs 0, no done; a fresh request afterwards is granted from requester 0.
